// File: rtl/lbd_cycle_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lbd_cycle_arbiter
// Description : Grants the shared CD<->LBD data path to one requester at a
//               time (bus master to memory, CPU to memory, CPU to bus).
//               Produces BDRY25/BDRY50 timing for CPU bus cycles and a TERM
//               watchdog pulse (TOUT_n). All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module lbd_cycle_arbiter #(
  parameter int BDRY_CYC = 4,     // cycles from CACT start to BDRY50
  parameter int TOUT_CYC = 63,    // max grant cycles waiting for TERM
  parameter bit FAIR     = 1'b1   // CPU memory request wins once after a bus grant
) (
  input  logic sysclk,
  input  logic sys_rst_n,
  input  logic TEST,
  input  logic BREQ_n,
  input  logic CREQ_n,
  input  logic CBREQ_n,
  input  logic TERM_n,
  output logic BGNT_n,
  output logic CGNT_n,
  output logic CGNT50_n,
  output logic CACT_n,
  output logic BDRY25_n,
  output logic BDRY50_n,
  output logic TOUT_n
);

  localparam int CNT_W = $clog2(TOUT_CYC + 1);
  localparam logic [CNT_W-1:0] c_TOUT_CNT   = CNT_W'(TOUT_CYC);
  localparam logic [CNT_W-1:0] c_BDRY25_CNT = CNT_W'(BDRY_CYC / 2);
  localparam logic [CNT_W-1:0] c_BDRY50_CNT = CNT_W'(BDRY_CYC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BGRANT  = 3'd1,
    S_CGRANT  = 3'd2,
    S_CACTIVE = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_bus;
  logic             r_bgnt_n;
  logic             r_cgnt_n;
  logic             r_cgnt50_n;
  logic             r_cact_n;
  logic             r_bdry25_n;
  logic             r_bdry50_n;
  logic             r_tout_n;

  logic             w_pick_bus;
  logic             w_timeout;
  logic [CNT_W-1:0] w_cnt_inc;

  // Bus master wins unless fairness hands this slot to a waiting CPU memory request.
  assign w_pick_bus = !BREQ_n && !(FAIR && r_last_bus && !CREQ_n);
  assign w_timeout  = (r_cnt == c_TOUT_CNT);
  // Grant-cycle counter saturates at the watchdog limit.
  assign w_cnt_inc  = w_timeout ? r_cnt : r_cnt + CNT_W'(1);

  // Arbitration FSM with registered grant, boundary and watchdog outputs.
  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last_bus <= 1'b0;
      r_bgnt_n   <= 1'b1;
      r_cgnt_n   <= 1'b1;
      r_cgnt50_n <= 1'b1;
      r_cact_n   <= 1'b1;
      r_bdry25_n <= 1'b1;
      r_bdry50_n <= 1'b1;
      r_tout_n   <= 1'b1;
    end else if (TEST) begin
      // Test mode parks the arbiter; fairness history is kept.
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bgnt_n   <= 1'b1;
      r_cgnt_n   <= 1'b1;
      r_cgnt50_n <= 1'b1;
      r_cact_n   <= 1'b1;
      r_bdry25_n <= 1'b1;
      r_bdry50_n <= 1'b1;
      r_tout_n   <= 1'b1;
    end else begin
      // TOUT_n is a single-cycle pulse; it only goes low on a watchdog release.
      r_tout_n <= 1'b1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_pick_bus) begin
            r_state    <= S_BGRANT;
            r_last_bus <= 1'b1;
            r_bgnt_n   <= 1'b0;
          end else if (!CREQ_n) begin
            r_state    <= S_CGRANT;
            r_last_bus <= 1'b0;
            r_cgnt_n   <= 1'b0;
          end else if (!CBREQ_n) begin
            r_state    <= S_CACTIVE;
            r_cact_n   <= 1'b0;
            r_bdry25_n <= !('0 >= c_BDRY25_CNT);
            r_bdry50_n <= !('0 >= c_BDRY50_CNT);
          end
        end
        S_BGRANT, S_CGRANT, S_CACTIVE: begin
          if (!TERM_n || w_timeout) begin
            // TERM has precedence over the watchdog on the same edge.
            r_state    <= S_RECOVER;
            r_cnt      <= '0;
            r_bgnt_n   <= 1'b1;
            r_cgnt_n   <= 1'b1;
            r_cgnt50_n <= 1'b1;
            r_cact_n   <= 1'b1;
            r_bdry25_n <= 1'b1;
            r_bdry50_n <= 1'b1;
            r_tout_n   <= !TERM_n;
          end else begin
            r_cnt <= w_cnt_inc;
            if (r_state == S_CGRANT) begin
              r_cgnt50_n <= 1'b0;
            end
            if (r_state == S_CACTIVE) begin
              r_bdry25_n <= !(w_cnt_inc >= c_BDRY25_CNT);
              r_bdry50_n <= !(w_cnt_inc >= c_BDRY50_CNT);
            end
          end
        end
        S_RECOVER: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign BGNT_n   = r_bgnt_n;
  assign CGNT_n   = r_cgnt_n;
  assign CGNT50_n = r_cgnt50_n;
  assign CACT_n   = r_cact_n;
  assign BDRY25_n = r_bdry25_n;
  assign BDRY50_n = r_bdry50_n;
  assign TOUT_n   = r_tout_n;

endmodule
`default_nettype wire
